ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-requester arbiter sharing the single-port 64000x32 on-chip RAM of the audio embedded system.
- Requester 0 is the audio sample DMA; requester 1 is the Nios host data master.
- Grants at most one access per clock, drives the RAM slave port and routes 1-cycle-latency read data back to the issuing requester.
- Suppresses accesses beyond the RAM depth.

Parameters:
- ADDR_W, 16, word address width of requesters and RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 64000, number of implemented RAM words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- freeze  in  1  high = no new grants issued.
- m0_chipselect, m1_chipselect  in  1  request valid.
- m0_write, m1_write  in  1  1 = write, 0 = read.
- m0_address, m1_address  in  ADDR_W  word address.
- m0_byteenable, m1_byteenable  in  DATA_W/8  byte lanes.
- m0_writedata, m1_writedata  in  DATA_W  write data.
- m0_waitrequest, m1_waitrequest  out  1  high = request not accepted this cycle.
- m0_readdatavalid, m1_readdatavalid  out  1  one-cycle pulse with read data.
- m0_readdata, m1_readdata  out  DATA_W  read data; 0 when readdatavalid is low.
- ram_address  out  ADDR_W  to RAM address.
- ram_byteenable  out  DATA_W/8  to RAM byteenable.
- ram_chipselect  out  1  to RAM chipselect.
- ram_write  out  1  to RAM write.
- ram_writedata  out  DATA_W  to RAM writedata.
- ram_clken  out  1  RAM clock enable; constant 1.
- ram_readdata  in  DATA_W  RAM q; valid the cycle after the read address is presented.

Behaviour:
- Reset: last_grant=1 (m0 wins first tie), rd_pend=0, rd_id=0, oob_pend=0. While reset is high, both waitrequests=1, ram_chipselect=0, ram_write=0, both readdatavalid=0, readdata=0.
- Grant: combinational each cycle from chipselects, freeze and last_grant.
  - Single requester: that requester wins.
  - Both requesting: winner is the requester not equal to last_grant.
  - freeze=1 or reset=1: no winner.
- Winner: waitrequest=0. Loser and idle requester: waitrequest=1 only if its chipselect=1, else 0.
- Requester hold rule: a stalled requester holds all inputs stable. The arbiter does not depend on this for correctness.
- RAM drive:
  - Winner's address, byteenable and writedata drive ram_* combinationally.
  - ram_chipselect=1 if there is a winner and address < DEPTH.
  - ram_write = winner write AND ram_chipselect.
  - No winner: ram_* hold 0.
- last_grant register updates to the winner id on every granted cycle; unchanged otherwise.
- Reads: a granted read sets rd_pend=1 and rd_id=winner for one cycle. In the next cycle, readdatavalid of rd_id=1 and readdata=ram_readdata. Latency is exactly 1 cycle. Back-to-back reads (one per cycle, either requester) are fully pipelined.
- Out-of-range read (address >= DEPTH): granted normally, RAM not selected. Next cycle, readdatavalid=1 with readdata=0.
- Out-of-range write: granted, dropped silently.
- Simultaneous events:
  - A read return and a new grant in the same cycle are independent.
  - A requester may receive readdatavalid and waitrequest=0 in the same cycle.
- Reset mid-read: pending return is discarded; no readdatavalid after reset rises.
- Freeze mid-read: a read already granted still returns the next cycle.
- Throughput:
  - Both requesters continuously requesting alternate grants: m0, m1, m0, ...
  - One requester alone gets 100% of cycles.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority; m0 always wins a tie, and last_grant is not implemented.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 0x0010 with byteenable 0xF, then m0 reads 0x0010 -> m0_waitrequest=0 both cycles; m0_readdatavalid=1 one cycle after the read with m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both continuously read addrs 0x0001/0x0002 for 6 cycles -> grant order m0,m1,m0,m1,m0,m1; each requester gets 3 valid returns, each 1 cycle after its grant, with correct data. With ARB_FIXED_PRIO_EN: m0 gets 6 grants, m1 waitrequest=1 throughout.
- m1 writes 0x12345678 to 0x0003 with byteenable 0b0101 over prior 0xFFFFFFFF, then reads -> readdata=0xFF34FF78.
- m0 writes to addr 64000 (0xFA00), then reads it -> ram_chipselect=0 both cycles; read returns readdatavalid=1, readdata=0; addr 0 contents unchanged.
- m0 read granted, reset asserted the next cycle -> m0_readdatavalid=0 during and after reset; after reset release, a simultaneous request is granted to m0 first.
- freeze=1 while m1 requests -> m1_waitrequest=1 and ram_chipselect=0 for every freeze cycle; a read granted the cycle before freeze still returns valid data.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester arbiter for the single-port on-chip audio RAM.
// Requester 0 is the audio sample DMA and requester 1 is the Nios host data master.
// The grant is combinational. Read data returns exactly one cycle after the grant.
// Addresses at or beyond DEPTH are granted but never reach the RAM.
// Optional macro ARB_FIXED_PRIO_EN: when it is defined, m0 always wins a tie and
// no last_grant state exists. When it is undefined (the default), ties are
// resolved round-robin.
module ram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                freeze,
  input  logic                m0_chipselect,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic                m0_readdatavalid,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic                m1_chipselect,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic                m1_readdatavalid,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int BE_W = DATA_W / 8;
  // The depth is widened by one bit so that a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              grant_vld_s;
  logic              grant_id_s;
  logic              sel_write_s;
  logic              in_range_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [BE_W-1:0]   sel_be_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              ret_vld_s;
  logic [DATA_W-1:0] ret_data_s;
  logic              rd_pend_r;
  logic              rd_id_r;
  logic              oob_pend_r;
`ifndef ARB_FIXED_PRIO_EN
  logic              last_grant_r;
`endif

  assign ram_clken = 1'b1;

  // Pick this cycle's winner from the chipselects, freeze and reset, resolving ties by policy.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (reset || freeze) begin
      grant_vld_s = 1'b0;
    end else if (m0_chipselect && m1_chipselect) begin
      grant_vld_s = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
      grant_id_s  = 1'b0;
`else
      grant_id_s  = ~last_grant_r;
`endif
    end else if (m0_chipselect) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (m1_chipselect) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
    end
  end

  // Multiplex the winner's request fields. All fields are zero when nobody is granted.
  always_comb begin
    sel_write_s = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_be_s    = {BE_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    if (grant_vld_s && grant_id_s) begin
      sel_write_s = m1_write;
      sel_addr_s  = m1_address;
      sel_be_s    = m1_byteenable;
      sel_wdata_s = m1_writedata;
    end else if (grant_vld_s) begin
      sel_write_s = m0_write;
      sel_addr_s  = m0_address;
      sel_be_s    = m0_byteenable;
      sel_wdata_s = m0_writedata;
    end else begin
      sel_write_s = 1'b0;
    end
    in_range_s = ({1'b0, sel_addr_s} < DEPTH_L);
  end

  // Drive the RAM port and the waitrequests. An out-of-range access is granted but not selected.
  always_comb begin
    ram_address    = sel_addr_s;
    ram_byteenable = sel_be_s;
    ram_writedata  = sel_wdata_s;
    ram_chipselect = grant_vld_s & in_range_s;
    ram_write      = sel_write_s & grant_vld_s & in_range_s;
    if (reset) begin
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
    end else begin
      m0_waitrequest = m0_chipselect & ~(grant_vld_s & ~grant_id_s);
      m1_waitrequest = m1_chipselect & ~(grant_vld_s & grant_id_s);
    end
  end

  // Route the one-cycle read return to its issuer. An out-of-range read returns zero.
  always_comb begin
    ret_vld_s  = rd_pend_r & ~reset;
    ret_data_s = ram_readdata;
    if (oob_pend_r) begin
      ret_data_s = {DATA_W{1'b0}};
    end else begin
      ret_data_s = ram_readdata;
    end
    m0_readdatavalid = ret_vld_s & ~rd_id_r;
    m1_readdatavalid = ret_vld_s & rd_id_r;
    if (m0_readdatavalid) begin
      m0_readdata = ret_data_s;
    end else begin
      m0_readdata = {DATA_W{1'b0}};
    end
    if (m1_readdatavalid) begin
      m1_readdata = ret_data_s;
    end else begin
      m1_readdata = {DATA_W{1'b0}};
    end
  end

  // Track the pending read return and the round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_r    <= 1'b0;
      rd_id_r      <= 1'b0;
      oob_pend_r   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_r <= 1'b1;
`endif
    end else begin
      rd_pend_r  <= grant_vld_s & ~sel_write_s;
      oob_pend_r <= grant_vld_s & ~sel_write_s & ~in_range_s;
      if (grant_vld_s && !sel_write_s) begin
        rd_id_r <= grant_id_s;
      end else begin
        rd_id_r <= rd_id_r;
      end
`ifndef ARB_FIXED_PRIO_EN
      if (grant_vld_s) begin
        last_grant_r <= grant_id_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for ram_port_arbiter with a behavioural RAM attached.
// The bench predicts the expected grants with its own arbitration model and keeps its own
// copy of the memory contents. It queues the expected read returns and compares them when
// they are due.
module tb_ram_port_arbiter;

  localparam int DEPTH = 64000;

  typedef struct packed {
    logic        cs;
    logic        we;
    logic [15:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } req_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, freeze;
  logic        m0_chipselect, m0_write, m1_chipselect, m1_write;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [15:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic exp_last;
  exp_t sb_q[$];

  logic [31:0] ram_mem [0:DEPTH-1];
  bit          ram_wr  [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          ref_wr  [0:DEPTH-1];

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .m0_chipselect(m0_chipselect), .m0_write(m0_write), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
    .m1_chipselect(m1_chipselect), .m1_write(m1_write), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  function automatic logic [31:0] init_word(input logic [15:0] a);
    return {a, ~a} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] ram_cur(input logic [15:0] a);
    return ram_wr[a] ? ram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_cur(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  // Behavioural single-port RAM with byte lanes and a one-cycle read latency.
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect && ram_address < 16'd64000) begin
      if (ram_write) begin
        ram_mem[ram_address] <= merge(ram_cur(ram_address), ram_writedata, ram_byteenable);
        ram_wr[ram_address]  <= 1'b1;
      end else begin
        ram_readdata <= ram_cur(ram_address);
      end
    end
  end

  // Count clock cycles so that each scoreboard entry can name the cycle its return is due in.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // Compare the read-return ports against the scoreboard on every falling edge.
  always @(negedge clk) begin
    logic        v0, v1;
    logic [31:0] d;
    exp_t        e;
    v0 = 1'b0;
    v1 = 1'b0;
    d  = 32'h0;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e  = sb_q.pop_front();
      v0 = ~e.id;
      v1 = e.id;
      d  = e.data;
    end
    chk("m0_rdvalid", {31'h0, m0_readdatavalid}, {31'h0, v0});
    chk("m1_rdvalid", {31'h0, m1_readdatavalid}, {31'h0, v1});
    chk("m0_rdata", m0_readdata, v0 ? d : 32'h0);
    chk("m1_rdata", m1_readdata, v1 ? d : 32'h0);
  end

  function automatic req_t idle();
    return '{cs: 1'b0, we: 1'b0, a: 16'h0, be: 4'h0, d: 32'h0};
  endfunction

  function automatic req_t rd(input logic [15:0] a);
    return '{cs: 1'b1, we: 1'b0, a: a, be: 4'hF, d: 32'h0};
  endfunction

  function automatic req_t wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    return '{cs: 1'b1, we: 1'b1, a: a, be: be, d: d};
  endfunction

  // Present one cycle of stimulus, predict its outcome, and check the grant-side outputs.
  task automatic step(input req_t r0, input req_t r1, input logic frz, input logic rst);
    logic win_v, win_id, inr;
    req_t w;
    @(posedge clk);
    #1;
    reset = rst;
    freeze = frz;
    m0_chipselect = r0.cs; m0_write = r0.we; m0_address = r0.a;
    m0_byteenable = r0.be; m0_writedata = r0.d;
    m1_chipselect = r1.cs; m1_write = r1.we; m1_address = r1.a;
    m1_byteenable = r1.be; m1_writedata = r1.d;
    win_v = 1'b0;
    win_id = 1'b0;
    w = idle();
    inr = 1'b0;
    if (rst) begin
      sb_q.delete();
      exp_last = 1'b1;
    end else if (!frz) begin
      if (r0.cs && r1.cs) begin
        win_v = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
        win_id = 1'b0;
`else
        win_id = ~exp_last;
`endif
      end else if (r0.cs) begin
        win_v = 1'b1;
        win_id = 1'b0;
      end else if (r1.cs) begin
        win_v = 1'b1;
        win_id = 1'b1;
      end
    end
    if (win_v) begin
      exp_last = win_id;
      w = win_id ? r1 : r0;
      inr = (w.a < 16'd64000);
      if (!w.we) begin
        sb_q.push_back('{id: win_id, data: (inr ? ref_cur(w.a) : 32'h0), due: cyc + 1});
      end else if (inr) begin
        ref_mem[w.a] = merge(ref_cur(w.a), w.d, w.be);
        ref_wr[w.a] = 1'b1;
      end
    end
    @(negedge clk);
    chk("m0_wait", {31'h0, m0_waitrequest}, {31'h0, rst | (r0.cs & ~(win_v & ~win_id))});
    chk("m1_wait", {31'h0, m1_waitrequest}, {31'h0, rst | (r1.cs & ~(win_v & win_id))});
    chk("ram_cs", {31'h0, ram_chipselect}, {31'h0, win_v & inr});
    chk("ram_we", {31'h0, ram_write}, {31'h0, win_v & inr & w.we});
    chk("ram_addr", {16'h0, ram_address}, {16'h0, win_v ? w.a : 16'h0});
    chk("ram_wdata", ram_writedata, win_v ? w.d : 32'h0);
  endtask

  initial begin
    req_t q0, q1;
    reset = 1'b1; freeze = 1'b0;
    m0_chipselect = 1'b0; m0_write = 1'b0; m0_address = 16'h0; m0_byteenable = 4'h0; m0_writedata = 32'h0;
    m1_chipselect = 1'b0; m1_write = 1'b0; m1_address = 16'h0; m1_byteenable = 4'h0; m1_writedata = 32'h0;
    exp_last = 1'b1;

    // Reset holds off everything, even with requests present.
    step(idle(), idle(), 1'b0, 1'b1);
    step(rd(16'h1), rd(16'h2), 1'b0, 1'b1);
    chk("clken", {31'h0, ram_clken}, 32'h1);

    // m0 writes and then reads back.
    step(wr(16'h0010, 4'hF, 32'hDEADBEEF), idle(), 1'b0, 1'b0);
    step(rd(16'h0010), idle(), 1'b0, 1'b0);
    step(idle(), idle(), 1'b0, 1'b0);
    chk("deadbeef_model", ref_cur(16'h0010), 32'hDEADBEEF);

    // m1 preloads 0xFFFFFFFF, which also leaves m1 as the last grant.
    step(idle(), wr(16'h0003, 4'hF, 32'hFFFFFFFF), 1'b0, 1'b0);

    // Both requesters read continuously: round-robin alternation, pipelined returns.
    for (int i = 0; i < 6; i++) step(rd(16'h0001), rd(16'h0002), 1'b0, 1'b0);
    step(idle(), idle(), 1'b0, 1'b0);

    // A partial byte-lane write over the preload.
    step(idle(), wr(16'h0003, 4'b0101, 32'h12345678), 1'b0, 1'b0);
    step(idle(), rd(16'h0003), 1'b0, 1'b0);
    chk("be_merge_model", ref_cur(16'h0003), 32'hFF34FF78);

    // Out-of-range write and read, then address 0 is untouched.
    step(wr(16'hFA00, 4'hF, 32'hCAFEF00D), idle(), 1'b0, 1'b0);
    step(rd(16'hFA00), idle(), 1'b0, 1'b0);
    step(rd(16'h0000), idle(), 1'b0, 1'b0);
    step(idle(), idle(), 1'b0, 1'b0);

    // A read is granted, then reset arrives and discards the return. After reset, m0 wins first.
    step(rd(16'h0005), idle(), 1'b0, 1'b0);
    step(idle(), idle(), 1'b0, 1'b1);
    step(idle(), idle(), 1'b0, 1'b1);
    step(rd(16'h0006), rd(16'h0007), 1'b0, 1'b0);
    step(idle(), idle(), 1'b0, 1'b0);

    // A read is granted just before freeze and still returns. m1 is stalled while frozen.
    step(rd(16'h0008), idle(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(idle(), rd(16'h0009), 1'b1, 1'b0);
    step(idle(), rd(16'h0009), 1'b0, 1'b0);
    step(idle(), idle(), 1'b0, 1'b0);

    // Mixed random traffic over a small address window plus out-of-range addresses.
    for (int i = 0; i < 40; i++) begin
      q0 = idle();
      q1 = idle();
      if ($urandom_range(0, 3) != 0) begin
        q0 = ($urandom_range(0, 1) == 1) ? wr(16'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom)
                                         : rd(($urandom_range(0, 7) == 0) ? 16'hFFF0 : 16'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 3) != 0) begin
        q1 = ($urandom_range(0, 1) == 1) ? wr(16'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom)
                                         : rd(16'($urandom_range(0, 7)));
      end
      step(q0, q1, ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 1'b0);
    end
    step(idle(), idle(), 1'b0, 1'b0);
    step(idle(), idle(), 1'b0, 1'b0);
    chk("sb_drained", sb_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
